axis_out_framer: RTL

- Output stage directly downstream of access_control; consumes its upscaled-pixel stream (ac_m_axis_*) and drives the external AXI-Stream master port.
- Buffers beats in a small FIFO so access_control is decoupled from sink backpressure.
- Generates per-row tlast and start-of-frame tuser from DST_IMG_WIDTH/DST_IMG_HEIGHT counters.
- Reports frame completion back to the control/register side.

---
 rtl/axis_out_framer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axis_out_framer.sv
// Output framer: buffers access_control beats in a FWFT FIFO and drives AXI-Stream with per-row tlast and start-of-frame tuser.
// One cycle from input accept to output valid when empty; input stalls when the FIFO is full or the frame's beats are all accepted.
module axis_out_framer #(
    parameter int AXISOUT_DATA_WIDTH = 24,
    parameter int AXISOUT_STRB_WIDTH = AXISOUT_DATA_WIDTH/8,
    parameter int DST_IMG_WIDTH      = 3840,
    parameter int DST_IMG_HEIGHT     = 2160,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          s_axis_tvalid,
    input  logic [AXISOUT_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                          s_axis_tready,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [AXISOUT_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXISOUT_STRB_WIDTH-1:0] m_axis_tkeep,
    output logic [AXISOUT_STRB_WIDTH-1:0] m_axis_tstrb,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tid,
    output logic                          m_axis_tdest,
    output logic                          busy,
    output logic                          frame_done
);
    localparam int PIX    = DST_IMG_WIDTH * DST_IMG_HEIGHT;
    localparam int COL_W  = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
    localparam int ROW_W  = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
    localparam int CNT_W  = $clog2(PIX + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                    state;
    logic [AXISOUT_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [FCNT_W-1:0]             count;
    logic [COL_W-1:0]              col;
    logic [ROW_W-1:0]              row;
    logic [CNT_W-1:0]              in_cnt;
    logic                          busy_q;
    logic                          done_q;
    logic                          push;
    logic                          pop;
    logic                          col_last;
    logic                          row_last;

    assign s_axis_tready = (state == S_RUN) && (count < FCNT_W'(FIFO_DEPTH))
                           && (in_cnt < CNT_W'(PIX));
    assign push          = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = (count != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;

    assign col_last = (col == COL_W'(DST_IMG_WIDTH - 1));
    assign row_last = (row == ROW_W'(DST_IMG_HEIGHT - 1));

    // Gating data with tvalid keeps the bus at zero while idle and after reset.
    assign m_axis_tdata = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign m_axis_tlast = m_axis_tvalid && col_last;
    assign m_axis_tuser = m_axis_tvalid && (col == '0) && (row == '0);
    assign m_axis_tkeep = '1;
    assign m_axis_tstrb = '1;
    assign m_axis_tid   = 1'b0;
    assign m_axis_tdest = 1'b0;
    assign busy         = busy_q;
    assign frame_done   = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + FCNT_W'(1);
                2'b01:   count <= count - FCNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            col    <= '0;
            row    <= '0;
            in_cnt <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                        col    <= '0;
                        row    <= '0;
                        in_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        in_cnt <= in_cnt + CNT_W'(1);
                    end
                    if (pop) begin
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                row    <= '0;
                                state  <= S_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
